// File: rtl/dsp_adder_arb_pkg.sv
// ============================================================================
//  Module      : dsp_adder_arb_pkg
//  Description : Shared definitions for the DSP adder arbiter: FSM state
//                encoding, default datapath width and the helper that
//                locates one requester's operand inside a packed bus.
//  Optional    : DSP_ADDER_ARB_CHECK_EN (used by dsp_adder_arbiter only)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_adder_arb_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // State encodings are fixed so that they stay stable across builds.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } state_t;

    // Bit offset of requester idx's operand in a bus packed at width bits per
    // requester. Used as the base of an indexed part-select.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin picker. Returns the first
//                asserted request at or above ptr, searching upward with
//                wrap-around.
//  Ports       : req       - request vector (NUM_REQ)
//                ptr       - search start index
//                grant     - one-hot grant (zero when no request)
//                grant_idx - binary index of the granted request
//                any       - at least one request is asserted
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    always_comb begin
        int          idx;
        logic [PTR_W-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr is always < NUM_REQ, so a single subtraction wraps it.
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = PTR_W'(idx);
            if (!any && req[sel]) begin
                any        = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dsp_adder_arbiter.sv
// ============================================================================
//  Module      : dsp_adder_arbiter
//  Description : Time-shares one DSP-tile adder between NUM_REQ requesters.
//                Operands are accepted over per-requester valid/ready,
//                driven to the adder from registers, and the result is
//                sampled ADDER_LAT+1 cycles later and returned on a
//                per-requester valid/ready response channel. Round-robin.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                req_valid/ready/a/b   - operand channel (packed per requester)
//                rsp_valid/ready/sum   - result channel (sum shared)
//                adder_input1/2        - registered operands to the adder
//                adder_out             - adder result
//                chk_err               - sticky adder mismatch flag
//                                        (only with DSP_ADDER_ARB_CHECK_EN)
//  Optional    : DSP_ADDER_ARB_CHECK_EN adds a fabric adder that cross-checks
//                the DSP result on every capture.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_adder_arbiter
    import dsp_adder_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ADDER_LAT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic [WIDTH-1:0]         adder_input1,
    output logic [WIDTH-1:0]         adder_input2,
`ifdef DSP_ADDER_ARB_CHECK_EN
    output logic                     chk_err,
`endif
    input  logic [WIDTH-1:0]         adder_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAT_W = (ADDER_LAT < 1) ? 1 : $clog2(ADDER_LAT + 1);
    localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'(ADDER_LAT);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [LAT_W-1:0]   lat_cnt;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic               accept;
    logic               exec_last;
    logic               rsp_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // rst_n gates the ready so nothing looks accepted while reset is held,
    // even though the FSM already sits in IDLE.
    assign req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign accept    = (state == IDLE) && grant_any;
    assign exec_last = (state == EXEC) && (lat_cnt == LAT_LAST);
    assign rsp_done  = (state == RESP) && rsp_ready[owner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            lat_cnt      <= '0;
            adder_input1 <= '0;
            adder_input2 <= '0;
            rsp_sum      <= '0;
            rsp_valid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        adder_input1 <= req_a[slice_lsb(int'(grant_idx), WIDTH) +: WIDTH];
                        adder_input2 <= req_b[slice_lsb(int'(grant_idx), WIDTH) +: WIDTH];
                        owner        <= grant_idx;
                        lat_cnt      <= '0;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_last) begin
                        rsp_sum   <= adder_out;
                        rsp_valid <= ONE_HOT0 << owner;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Only the owner's ready can retire the response.
                    if (rsp_done) begin
                        rsp_valid <= '0;
                        rr_ptr    <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= '0;
                end
            endcase
        end
    end

`ifdef DSP_ADDER_ARB_CHECK_EN
    logic [WIDTH-1:0] fabric_sum;

    // Independent fabric adder; the operand registers are stable for the
    // whole EXEC window, so compare on the same cycle the DSP result is taken.
    assign fabric_sum = adder_input1 + adder_input2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err <= 1'b0;
        end else if (exec_last && (fabric_sum != adder_out)) begin
            chk_err <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dsp_adder_arbiter.sv
// ============================================================================
//  Module      : tb_dsp_adder_arbiter
//  Description : Directed bench for dsp_adder_arbiter. One instance with a
//                combinational adder (ADDER_LAT=0) and one with a two-stage
//                pipelined adder (ADDER_LAT=2). Expected values are
//                hand-computed constants.
//  Optional    : DSP_ADDER_ARB_CHECK_EN enables the chk_err scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsp_adder_arbiter;

    logic clk;
    logic rst_n;
    logic [31:0] bias;

    int checks;
    int failures;

    // ---------------- instance with combinational adder ----------------
    logic [3:0]   rv0, rr0, sv0, sr0;
    logic [127:0] ra0, rb0;
    logic [31:0]  sum0, ai1_0, ai2_0, ao0;
    logic         ce0;

    // ---------------- instance with 2-cycle adder ----------------------
    logic [3:0]   rv2, rr2, sv2, sr2;
    logic [127:0] ra2, rb2;
    logic [31:0]  sum2, ai1_2, ai2_2, ao2;
    logic [31:0]  pipe1, pipe2;
    logic         ce2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder models; bias lets the checker scenario corrupt the result.
    assign ao0 = ai1_0 + ai2_0 + bias;
    always @(posedge clk) begin
        pipe1 <= ai1_2 + ai2_2 + bias;
        pipe2 <= pipe1;
    end
    assign ao2 = pipe2;

    dsp_adder_arbiter #(.NUM_REQ(4), .WIDTH(32), .ADDER_LAT(0)) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (rv0),
        .req_ready    (rr0),
        .req_a        (ra0),
        .req_b        (rb0),
        .rsp_valid    (sv0),
        .rsp_ready    (sr0),
        .rsp_sum      (sum0),
        .adder_input1 (ai1_0),
        .adder_input2 (ai2_0),
`ifdef DSP_ADDER_ARB_CHECK_EN
        .chk_err      (ce0),
`endif
        .adder_out    (ao0)
    );

    dsp_adder_arbiter #(.NUM_REQ(4), .WIDTH(32), .ADDER_LAT(2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (rv2),
        .req_ready    (rr2),
        .req_a        (ra2),
        .req_b        (rb2),
        .rsp_valid    (sv2),
        .rsp_ready    (sr2),
        .rsp_sum      (sum2),
        .adder_input1 (ai1_2),
        .adder_input2 (ai2_2),
`ifdef DSP_ADDER_ARB_CHECK_EN
        .chk_err      (ce2),
`endif
        .adder_out    (ao2)
    );

`ifndef DSP_ADDER_ARB_CHECK_EN
    assign ce0 = 1'b0;
    assign ce2 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op0(input int i, input logic [31:0] a, input logic [31:0] b);
        ra0[i*32 +: 32] = a;
        rb0[i*32 +: 32] = b;
    endtask

    task automatic set_op2(input int i, input logic [31:0] a, input logic [31:0] b);
        ra2[i*32 +: 32] = a;
        rb2[i*32 +: 32] = b;
    endtask

    int          order [5];
    logic [31:0] exp_sum [4];
    logic [3:0]  g_oh;

    initial begin
        checks   = 0;
        failures = 0;
        order    = '{0, 1, 2, 3, 0};
        exp_sum  = '{32'h11111112, 32'h22222224, 32'h33333336, 32'h44444448};
        bias  = 32'd0;
        rst_n = 1'b0;
        ra0 = '0; rb0 = '0; sr0 = '0;
        ra2 = '0; rb2 = '0; sr2 = '0;
        // Valids high during reset: ready must still be held low.
        rv0 = 4'b1111;
        rv2 = 4'b1111;
        repeat (2) @(negedge clk);
        chk("rst_req_ready0", rr0, 4'b0000);
        chk("rst_req_ready2", rr2, 4'b0000);
        chk("rst_rsp_valid0", sv0, 4'b0000);
        chk("rst_rsp_sum0", sum0, 32'h0);
        chk("rst_adder_in1", ai1_0, 32'h0);
        chk("rst_adder_in2", ai2_0, 32'h0);
        chk("rst_rsp_sum2", sum2, 32'h0);
        rv0 = '0;
        rv2 = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // ---- single requester 1: 5 + 7 ----
        set_op0(1, 32'h5, 32'h7);
        rv0 = 4'b0010;
        #1 chk("t1_req_ready", rr0, 4'b0010);
        @(negedge clk);
        rv0 = '0;
        #1;
        chk("t1_exec_ready", rr0, 4'b0000);
        chk("t1_exec_valid", sv0, 4'b0000);
        chk("t1_adder_in1", ai1_0, 32'h5);
        chk("t1_adder_in2", ai2_0, 32'h7);
        @(negedge clk);
        chk("t1_rsp_valid", sv0, 4'b0010);
        chk("t1_rsp_sum", sum0, 32'h0000000C);
        sr0 = 4'b1111;
        @(negedge clk);
        chk("t1_rsp_cleared", sv0, 4'b0000);

        // ---- overflow, requester 3 alone, rr_ptr = 2 ----
        set_op0(3, 32'hFFFFFFFF, 32'h2);
        rv0 = 4'b1000;
        #1 chk("ovf_req_ready", rr0, 4'b1000);
        @(negedge clk);
        rv0 = '0;
        @(negedge clk);
        chk("ovf_rsp_valid", sv0, 4'b1000);
        chk("ovf_rsp_sum", sum0, 32'h00000001);
        chk("ovf_in_hold", ai1_0, 32'hFFFFFFFF);
        @(negedge clk);

        // ---- all four valid, rsp_ready all high: order 0,1,2,3,0 ----
        set_op0(0, 32'h11111111, 32'h1);
        set_op0(1, 32'h22222222, 32'h2);
        set_op0(2, 32'h33333333, 32'h3);
        set_op0(3, 32'h44444444, 32'h4);
        rv0 = 4'b1111;
        for (int k = 0; k < 15; k++) begin
            #1;
            g_oh = 4'b0001 << order[k / 3];
            case (k % 3)
                0: chk($sformatf("rr_grant_%0d", k / 3), rr0, g_oh);
                1: chk($sformatf("rr_exec_%0d", k / 3), rr0, 4'b0000);
                default: begin
                    chk($sformatf("rr_valid_%0d", k / 3), sv0, g_oh);
                    chk($sformatf("rr_sum_%0d", k / 3), sum0, exp_sum[order[k / 3]]);
                    if (k == 14) rv0 = '0;
                end
            endcase
            @(negedge clk);
        end

        // ---- ADDER_LAT=2 back-pressure on requester 2 ----
        set_op2(2, 32'h00001234, 32'h00004321);
        rv2 = 4'b0100;
        #1 chk("bp_req_ready", rr2, 4'b0100);
        @(negedge clk);
        rv2 = 4'b1011;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk($sformatf("bp_exec_valid_%0d", j), sv2, 4'b0000);
            chk($sformatf("bp_exec_ready_%0d", j), rr2, 4'b0000);
            @(negedge clk);
        end
        for (int j = 0; j < 10; j++) begin
            #1;
            chk($sformatf("bp_hold_valid_%0d", j), sv2, 4'b0100);
            chk($sformatf("bp_hold_sum_%0d", j), sum2, 32'h00005555);
            chk($sformatf("bp_hold_ready_%0d", j), rr2, 4'b0000);
            @(negedge clk);
        end
        sr2 = 4'b1011;
        @(negedge clk);
        #1 chk("bp_nonowner_ignored", sv2, 4'b0100);
        sr2 = 4'b0100;
        @(negedge clk);
        #1;
        chk("bp_released", sv2, 4'b0000);
        chk("bp_next_grant", rr2, 4'b1000);
        rv2 = '0;
        sr2 = '0;

        // ---- requester 0 alone with rr_ptr = 1, then reset during EXEC ----
        set_op0(0, 32'hA5A5A5A5, 32'h5A5A5A5A);
        rv0 = 4'b0001;
        #1 chk("mr_wrap_grant", rr0, 4'b0001);
        @(negedge clk);
        rv0 = '0;
        rst_n = 1'b0;
        #1;
        chk("mr_adder_in1", ai1_0, 32'h0);
        chk("mr_adder_in2", ai2_0, 32'h0);
        chk("mr_rsp_sum", sum0, 32'h0);
        chk("mr_rsp_valid", sv0, 4'b0000);
        chk("mr_req_ready", rr0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("mr_no_rsp_%0d", j), sv0, 4'b0000);
        end
        rv0 = 4'b1111;
        #1 chk("mr_grant_after_reset", rr0, 4'b0001);
        rv0 = '0;

`ifdef DSP_ADDER_ARB_CHECK_EN
        // ---- corrupted adder: chk_err sets on capture and sticks ----
        @(negedge clk);
        chk("ck_initial0", ce0, 1'b0);
        chk("ck_initial2", ce2, 1'b0);
        bias = 32'd1;
        set_op0(2, 32'h1, 32'h1);
        rv0 = 4'b0100;
        @(negedge clk);
        rv0 = '0;
        chk("ck_before_capture", ce0, 1'b0);
        @(negedge clk);
        chk("ck_after_capture", ce0, 1'b1);
        chk("ck_bad_sum", sum0, 32'h3);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("ck_sticky_%0d", j), ce0, 1'b1);
        end
        rst_n = 1'b0;
        #1 chk("ck_reset_clears", ce0, 1'b0);
        bias = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dsp_adder_arbiter.md
# dsp_adder_arbiter

Time-shares the single 32-bit DSP adder (`adder`, operands `input1`/`input2`, result `out`) between NUM_REQ independent requesters. Each requester presents one operand pair over a valid/ready handshake and receives its sum on a per-requester valid/ready response channel. Grants are round-robin. The block drives the adder operands from registers and samples the adder result after a configurable latency, so the adder may be combinational or pipelined inside the DSP tile.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- ADDER_LAT, 0, adder pipeline depth in cycles (0 = combinational)
- clk  in  1  system clock (48 MHz SB_HFOSC domain)
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- rsp_valid  out  NUM_REQ  result valid, one-hot or zero
- rsp_ready  in  NUM_REQ  per-requester result accept
- rsp_sum  out  WIDTH  result, shared by all requesters
- adder_input1  out  WIDTH  to `adder.input1`
- adder_input2  out  WIDTH  to `adder.input2`
- adder_out  in  WIDTH  from `adder.out`

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant = first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - req_ready[grant] is asserted combinationally, only in IDLE.
  - On handshake: register operands into adder_input1/2, latch grant into owner, clear lat_cnt, go to EXEC.
- **EXEC**
  - Lasts ADDER_LAT+1 cycles, counted by lat_cnt.
  - On the final cycle: rsp_sum <= adder_out, go to RESP.
- **RESP**
  - rsp_valid[owner] = 1.
  - On rsp_ready[owner]: rr_ptr <= owner+1 mod NUM_REQ, go to IDLE.
  - rsp_ready from non-owners is ignored.
- Requesters hold req_valid and operands stable until req_ready. req_ready never asserts outside IDLE.
- Arithmetic: sum = (a + b) mod 2^WIDTH. Carry-out is discarded.
- adder_input1/2 hold their values after EXEC, until the next accept.
- rsp_sum holds its value until the next capture.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - req_ready = 0 while rst_n is low, then follows IDLE arbitration.
  - rsp_valid = 0, rsp_sum = 0, adder_input1/2 = 0, lat_cnt = 0.
- Latency, accept edge to first rsp_valid cycle: ADDER_LAT+2 cycles.
- Minimum issue interval: ADDER_LAT+3 cycles per transaction, when rsp_ready is already high.
- Back-pressure: rsp_ready low holds RESP indefinitely. No other requester is accepted meanwhile.
- Single active requester: granted on every IDLE visit regardless of rr_ptr.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Simultaneous valids: the lowest index at or above rr_ptr wins.
- Reset mid-operation: the transaction is dropped, no response is issued, and all state returns to reset values asynchronously.

## Configuration
- Macro: DSP_ADDER_ARB_CHECK_EN.
- With the macro defined:
  - Adds output `chk_err` (1 bit, reset 0).
  - On the EXEC capture cycle, a fabric adder computes adder_input1 + adder_input2.
  - If this differs from adder_out, chk_err sets and stays set until reset.
- Without the macro: the port and all checking logic are absent.

## Structure
- Shared package `dsp_adder_arb_pkg`: state encoding localparams (IDLE=2'd0, EXEC=2'd1, RESP=2'd2), default WIDTH, and the operand slice helper.
- Sub-module `rr_arbiter`, purely combinational:
  - Inputs: req[NUM_REQ], ptr.
  - Outputs: one-hot grant, binary grant index, any.
- FSM, latency counter, operand/result registers and checker live in `dsp_adder_arbiter`.

## Test plan
- Single requester, ADDER_LAT=0: req 1 sends a=0x00000005, b=0x00000007 -> req_ready[1] in the accept cycle, rsp_valid[1] 2 cycles later, rsp_sum=0x0000000C.
- All four valid continuously with rsp_ready=1111 -> grants in order 0,1,2,3,0. Each transaction spans exactly 3 cycles.
- Overflow: a=0xFFFFFFFF, b=0x00000002 -> rsp_sum=0x00000001.
- Back-pressure, ADDER_LAT=2: rsp_ready[2]=0 for 10 cycles -> rsp_valid[2] held with stable rsp_sum, req_ready=0 throughout; accept latency to rsp_valid = 4 cycles.
- rst_n pulsed low during EXEC -> no rsp_valid. All outputs zero. rr_ptr=0, so the next grant goes to requester 0 when all are valid.
- With DSP_ADDER_ARB_CHECK_EN, the bench adder model is forced to return a+b+1 -> chk_err=1 after the first capture and remains 1 until reset.
